// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared constants, state type and helpers for the 4-way round-robin arbiter
package rr_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Priority pointer after a release: the requester just served drops to lowest priority.
    function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] cur);
        return cur + SEL_W'(1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating-priority search starting at ptr
module rr_pick
    import rr_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [SEL_W-1:0]   idx,
    output logic               any
);

    logic [SEL_W-1:0] cand;

    // Walk offsets from the far end back toward ptr so the closest set bit wins.
    always_comb begin
        idx  = ptr;
        any  = |req;
        cand = ptr;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = ptr + SEL_W'(i);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter4.sv
// rtl/rr_arbiter4.sv - 4-requester round-robin arbiter with hold timeout
module rr_arbiter4
    import rr_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [SEL_W-1:0]   sel,
    output logic               gnt_valid,
    output logic               timeout
);

    // The counter holds (valid cycles completed - 1) while granted, so the
    // limit is reached on the edge that ends the TIMEOUT-th valid cycle.
    localparam int CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam bit               TO_EN   = (TIMEOUT != 0);

    arb_state_t       state;
    logic [SEL_W-1:0] ptr;
    logic [CNT_W-1:0] cnt;

    logic [SEL_W-1:0] pick_idx;
    logic             pick_any;
    logic             owner_req;
    logic             limit_hit;
    logic             release_now;

    rr_pick u_pick (
        .req (req),
        .ptr (ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Release conditions evaluated for the current owner; done wins over the counter.
    always_comb begin
        owner_req   = req[sel];
        limit_hit   = TO_EN && (cnt == LIMIT);
        release_now = done || !owner_req || limit_hit;
    end

    // Two-state grant FSM; every output is a flop so no input reaches an output combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sel       <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
            ptr       <= '0;
            cnt       <= '0;
        end else begin
            timeout <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pick_any) begin
                        sel       <= pick_idx;
                        gnt_valid <= 1'b1;
                        cnt       <= '0;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        gnt_valid <= 1'b0;
                        ptr       <= next_ptr(sel);
                        timeout   <= limit_hit && !done && owner_req;
                        state     <= IDLE;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    gnt_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
